// File: rtl/hazard_forward_unit.sv
// Tracks in-flight destination tags and produces the ALU forwarding selects, the load-use stall and the EX bubble.
// The selects are registered one clock after decode. stallIF and bubbleEX are combinational from the current state.
// memReady low freezes all tag state, the selects and the advance; stallIF is held high and stall cycles are counted.
module hazard_forward_unit #(
   parameter int REG_BITS = 4,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                idValid,
   input  logic [REG_BITS-1:0] idRs1,
   input  logic [REG_BITS-1:0] idRs2,
   input  logic [REG_BITS-1:0] idRd,
   input  logic                idRegWrite,
   input  logic                idMemRead,
   input  logic                memReady,
   input  logic                branchTaken,
   output logic [1:0]          Fa,
   output logic [1:0]          Fb,
   output logic                stallIF,
   output logic                bubbleEX,
   output logic [CNT_BITS-1:0] stallCount
);

   typedef struct packed {
      logic                valid;
      logic [REG_BITS-1:0] rd;
      logic                regWrite;
      logic                memRead;
   } entry_t;

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b10;
   localparam logic [1:0] SEL_WB  = 2'b11;

   // EX keeps the full entry because loadUse needs memRead. The MEM entry is
   // only ever a forwarding source, so its memRead bit is not kept, and the
   // entry leaving MEM is never consulted again, so no WB tag is stored.
   entry_t              r_ex;
   logic                r_memValid;
   logic [REG_BITS-1:0] r_memRd;
   logic                r_memRegWrite;
   logic [1:0]          r_fa;
   logic [1:0]          r_fb;
   logic [CNT_BITS-1:0] r_stallCount;

   logic                w_adv;
   logic                w_loadUse;
   logic                w_bubble;
   entry_t              w_newEx;
   logic                w_exProd;
   logic                w_memProd;
   logic [1:0]          w_faNext;
   logic [1:0]          w_fbNext;

   assign w_adv = memReady;

   // Hazard detection, next EX entry and next forwarding selects.
   always_comb begin
      w_exProd  = r_ex.valid & r_ex.regWrite & (r_ex.rd != '0);
      w_memProd = r_memValid & r_memRegWrite & (r_memRd != '0);

      w_loadUse = idValid & w_exProd & r_ex.memRead &
                  ((r_ex.rd == idRs1) | (r_ex.rd == idRs2));
      w_bubble  = branchTaken | w_loadUse;

      w_newEx          = '0;
      if (!w_bubble) begin
         w_newEx.valid    = idValid;
         w_newEx.rd       = idRd;
         w_newEx.regWrite = idRegWrite & idValid;
         w_newEx.memRead  = idMemRead & idValid;
      end

      // The younger producer (currently in EX, about to be in MEM) wins.
      w_faNext = SEL_RF;
      w_fbNext = SEL_RF;
      if (!w_bubble) begin
         if (w_exProd && (r_ex.rd == idRs1))       w_faNext = SEL_MEM;
         else if (w_memProd && (r_memRd == idRs1)) w_faNext = SEL_WB;
         if (w_exProd && (r_ex.rd == idRs2))       w_fbNext = SEL_MEM;
         else if (w_memProd && (r_memRd == idRs2)) w_fbNext = SEL_WB;
      end
   end

   // Stage shift and select registers move only when memory is ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex          <= '0;
         r_memValid    <= 1'b0;
         r_memRd       <= '0;
         r_memRegWrite <= 1'b0;
         r_fa          <= SEL_RF;
         r_fb          <= SEL_RF;
      end else if (w_adv) begin
         r_ex          <= w_newEx;
         r_memValid    <= r_ex.valid;
         r_memRd       <= r_ex.rd;
         r_memRegWrite <= r_ex.regWrite;
         r_fa          <= w_faNext;
         r_fb          <= w_fbNext;
      end
   end

   // Saturating count of cycles in which fetch is held, including freezes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stallCount <= '0;
      end else if (stallIF && (r_stallCount != '1)) begin
         r_stallCount <= r_stallCount + 1'b1;
      end
   end

   assign stallIF    = ~memReady | (w_loadUse & ~branchTaken);
   assign bubbleEX   = memReady & w_bubble;
   assign Fa         = r_fa;
   assign Fb         = r_fb;
   assign stallCount = r_stallCount;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding, load-use, freeze, branch,
// counter saturation and asynchronous reset, each checked against hand values.
module tb_hazard_forward_unit;
   logic        clk;
   logic        rst_n;
   logic        idValid;
   logic [3:0]  idRs1, idRs2, idRd;
   logic        idRegWrite, idMemRead;
   logic        memReady, branchTaken;
   logic [1:0]  Fa, Fb;
   logic        stallIF, bubbleEX;
   logic [15:0] stallCount;

   int checks = 0;
   int errors = 0;
   int exp_sc = 0;

   hazard_forward_unit #(.REG_BITS(4), .CNT_BITS(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd),
      .idRegWrite(idRegWrite), .idMemRead(idMemRead),
      .memReady(memReady), .branchTaken(branchTaken),
      .Fa(Fa), .Fb(Fb), .stallIF(stallIF), .bubbleEX(bubbleEX),
      .stallCount(stallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic rw, input logic mr);
      idValid = v; idRs1 = rs1; idRs2 = rs2; idRd = rd; idRegWrite = rw; idMemRead = mr;
   endtask

   task automatic nop();
      set_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic flush();
      nop();
      repeat (3) tick();
   endtask

   initial begin
      rst_n = 1'b0; memReady = 1'b1; branchTaken = 1'b0;
      nop();
      #12;
      chk("reset_Fa", Fa, 2'b00);
      chk("reset_Fb", Fb, 2'b00);
      chk("reset_count", stallCount, 16'd0);
      chk("reset_stallIF", stallIF, 1'b0);
      chk("reset_bubbleEX", bubbleEX, 1'b0);
      rst_n = 1'b1;

      // ADD r1,r2,r3 then SUB r2,r1,r3 back-to-back
      set_id(1, 4'd2, 4'd3, 4'd1, 1, 0); tick();
      set_id(1, 4'd1, 4'd3, 4'd2, 1, 0); tick();
      chk("b2b_Fa", Fa, 2'b10);
      chk("b2b_Fb", Fb, 2'b00);
      flush();

      // ADD r1, NOP, SUB r2,r1,r1
      set_id(1, 4'd2, 4'd3, 4'd1, 1, 0); tick();
      nop(); tick();
      set_id(1, 4'd1, 4'd1, 4'd2, 1, 0); tick();
      chk("gap_Fa", Fa, 2'b11);
      chk("gap_Fb", Fb, 2'b11);

      // r1 written in both EX/MEM and MEM/WB: younger wins
      set_id(1, 4'd2, 4'd3, 4'd1, 1, 0); tick();
      set_id(1, 4'd2, 4'd3, 4'd1, 1, 0); tick();
      set_id(1, 4'd1, 4'd1, 4'd2, 1, 0); tick();
      chk("prio_Fa", Fa, 2'b10);
      chk("prio_Fb", Fb, 2'b10);
      flush();

      // LDR r4 then ADD r5,r4,r6
      set_id(1, 4'd2, 4'd0, 4'd4, 1, 1); tick();
      set_id(1, 4'd4, 4'd6, 4'd5, 1, 0); #1;
      chk("lu_stallIF", stallIF, 1'b1);
      chk("lu_bubbleEX", bubbleEX, 1'b1);
      tick(); exp_sc = exp_sc + 1; #1;
      chk("lu_stallIF_drop", stallIF, 1'b0);
      chk("lu_bubbleEX_drop", bubbleEX, 1'b0);
      chk("lu_bubble_Fa", Fa, 2'b00);
      chk("lu_count", stallCount, exp_sc);
      tick();
      chk("lu_Fa", Fa, 2'b11);
      chk("lu_Fb", Fb, 2'b00);
      flush();

      // producer with rd=0 and consumers of r0
      set_id(1, 4'd2, 4'd3, 4'd0, 1, 0); tick();
      set_id(1, 4'd0, 4'd0, 4'd5, 1, 0); tick();
      chk("r0_ex_Fa", Fa, 2'b00);
      chk("r0_ex_Fb", Fb, 2'b00);
      set_id(1, 4'd0, 4'd0, 4'd6, 1, 0); tick();
      set_id(1, 4'd0, 4'd0, 4'd6, 1, 0); tick();
      chk("r0_mem_Fa", Fa, 2'b00);
      chk("r0_mem_Fb", Fb, 2'b00);
      set_id(1, 4'd2, 4'd3, 4'd0, 1, 1); tick();
      set_id(1, 4'd0, 4'd0, 4'd7, 1, 0); #1;
      chk("r0_load_nostall", stallIF, 1'b0);
      flush();

      // memReady low for three cycles mid-sequence
      set_id(1, 4'd2, 4'd3, 4'd1, 1, 0); tick();
      set_id(1, 4'd1, 4'd3, 4'd2, 1, 0); tick();
      set_id(1, 4'd1, 4'd2, 4'd7, 1, 0);
      memReady = 1'b0; #1;
      chk("frz_stallIF", stallIF, 1'b1);
      chk("frz_bubbleEX", bubbleEX, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(); exp_sc = exp_sc + 1;
         chk("frz_Fa", Fa, 2'b10);
         chk("frz_Fb", Fb, 2'b00);
         chk("frz_stallIF_cyc", stallIF, 1'b1);
      end
      memReady = 1'b1; #1;
      chk("frz_count", stallCount, exp_sc);
      chk("frz_release_stallIF", stallIF, 1'b0);
      tick();
      chk("frz_after_Fa", Fa, 2'b11);
      chk("frz_after_Fb", Fb, 2'b10);
      flush();

      // load-use coincident with a taken branch
      set_id(1, 4'd2, 4'd0, 4'd4, 1, 1); tick();
      set_id(1, 4'd4, 4'd6, 4'd5, 1, 0);
      branchTaken = 1'b1; #1;
      chk("br_stallIF", stallIF, 1'b0);
      chk("br_bubbleEX", bubbleEX, 1'b1);
      tick();
      chk("br_count", stallCount, exp_sc);
      chk("br_Fa", Fa, 2'b00);
      branchTaken = 1'b0;
      flush();

      // saturation, then asynchronous reset mid-stall
      set_id(1, 4'd2, 4'd3, 4'd1, 1, 0); tick();
      set_id(1, 4'd1, 4'd3, 4'd2, 1, 0); tick();
      memReady = 1'b0;
      repeat (65538) tick();
      chk("sat_count", stallCount, 16'hFFFF);
      chk("sat_Fa_held", Fa, 2'b10);
      rst_n = 1'b0; #1;
      chk("arst_Fa", Fa, 2'b00);
      chk("arst_count", stallCount, 16'd0);
      chk("arst_stallIF_frozen", stallIF, 1'b1);
      memReady = 1'b1; #1;
      chk("arst_stallIF", stallIF, 1'b0);
      chk("arst_bubbleEX", bubbleEX, 1'b0);
      rst_n = 1'b1;
      nop(); tick();
      chk("arst_count_after", stallCount, 16'd0);
      chk("arst_Fb_after", Fb, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
